// File: rtl/breakout_pkg.sv
// Shared constants, types and geometry helpers for the breakout brick column.
package breakout_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned HP_W    = 2;

    localparam int DEF_NUM_ROWS   = 8;
    localparam int DEF_X_LEFT     = 461;
    localparam int DEF_X_RIGHT    = 566;
    localparam int DEF_Y_TOP      = 4;
    localparam int DEF_ROW_H      = 16;
    localparam int DEF_ROW_GAP    = 7;
    localparam int DEF_EDGE       = 3;
    localparam int DEF_EXT        = 7;
    localparam int DEF_HIT_POINTS = 1;
    localparam int DEF_POINTS     = 4;
    localparam int DEF_SCORE_W    = 8;

    typedef enum logic {
        StIdle,
        StLock
    } lock_state_e;

    // Contact sides of one brick, MSB first: up, down, left, right.
    typedef struct packed {
        logic u;
        logic d;
        logic l;
        logic r;
    } sides_t;

    function automatic int row_top(input int y_top, input int row_h, input int row_gap,
                                   input int r);
        return y_top + r * (row_h + row_gap);
    endfunction

endpackage

// File: rtl/breakout_block_column_contact.sv
// Combinational four-side contact test of the ball box against one brick.
module brick_contact
    import breakout_pkg::*;
#(
    parameter int X_LEFT  = DEF_X_LEFT,
    parameter int X_RIGHT = DEF_X_RIGHT,
    parameter int ROW_YT  = DEF_Y_TOP,
    parameter int ROW_YB  = DEF_Y_TOP + DEF_ROW_H - 1,
    parameter int EDGE    = DEF_EDGE,
    parameter int EXT     = DEF_EXT
) (
    input  logic               live,
    input  logic [COORD_W-1:0] ball_x_l,
    input  logic [COORD_W-1:0] ball_x_r,
    input  logic [COORD_W-1:0] ball_y_t,
    input  logic [COORD_W-1:0] ball_y_b,
    output sides_t             contact
);

    int   xl, xr, yt, yb;
    logic y_overlap;
    logic x_window;

    // Signed arithmetic so X_LEFT-EXT may go below zero without wrapping.
    always_comb begin
        xl        = {{(32 - COORD_W){1'b0}}, ball_x_l};
        xr        = {{(32 - COORD_W){1'b0}}, ball_x_r};
        yt        = {{(32 - COORD_W){1'b0}}, ball_y_t};
        yb        = {{(32 - COORD_W){1'b0}}, ball_y_b};
        y_overlap = (yb >= ROW_YT) && (yt <= ROW_YB);
        x_window  = (xl >= X_LEFT - EXT) && (xr <= X_RIGHT + EXT);
        contact   = '0;
        if (live) begin
            contact.r = (xl >= X_RIGHT - EDGE) && (xl <= X_RIGHT) && y_overlap;
            contact.l = (xr >= X_LEFT) && (xr <= X_LEFT + EDGE) && y_overlap;
            contact.d = x_window && (yt >= ROW_YB - EDGE) && (yt <= ROW_YB);
            contact.u = x_window && (yb >= ROW_YT) && (yb <= ROW_YT + EDGE);
        end
    end

endmodule

// File: rtl/breakout_block_column.sv
// Brick column: draws live bricks, detects ball contact, services one hit per
// ball pass and keeps HP, destroyed-brick count, score and cleared flag.
module breakout_block_column
    import breakout_pkg::*;
#(
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int X_LEFT     = DEF_X_LEFT,
    parameter int X_RIGHT    = DEF_X_RIGHT,
    parameter int Y_TOP      = DEF_Y_TOP,
    parameter int ROW_H      = DEF_ROW_H,
    parameter int ROW_GAP    = DEF_ROW_GAP,
    parameter int EDGE       = DEF_EDGE,
    parameter int EXT        = DEF_EXT,
    parameter int HIT_POINTS = DEF_HIT_POINTS,
    parameter int POINTS     = DEF_POINTS,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] ball_x_l,
    input  logic [COORD_W-1:0] ball_x_r,
    input  logic [COORD_W-1:0] ball_y_t,
    input  logic [COORD_W-1:0] ball_y_b,
    output logic               moveU,
    output logic               moveD,
    output logic               moveL,
    output logic               moveR,
    output logic               col_on,
    output logic [1:0]         col_shade,
    output logic [4:0]         hit_count,
    output logic [SCORE_W-1:0] score,
    output logic               cleared
);

    localparam logic [HP_W-1:0] HP_FULL   = HP_W'(HIT_POINTS);
    localparam int              SCORE_MAX = (1 << SCORE_W) - 1;

    logic [COORD_W-1:0]            bxl_q, bxr_q, byt_q, byb_q;
    sides_t [NUM_ROWS-1:0]         contact_d, contact_q;
    logic [NUM_ROWS-1:0][HP_W-1:0] hp_q, hp_d;
    logic [NUM_ROWS-1:0]           row_live, row_contact, svc_sel;
    sides_t                        svc_sides, move_q, move_d;
    lock_state_e                   state_q, state_d;
    logic [4:0]                    hit_count_q, hit_count_d;
    logic [SCORE_W-1:0]            score_q, score_d;
    logic                          cleared_q, cleared_d;
    logic                          any_contact, fire, killed;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        localparam int YT = row_top(Y_TOP, ROW_H, ROW_GAP, r);

        brick_contact #(
            .X_LEFT (X_LEFT),
            .X_RIGHT(X_RIGHT),
            .ROW_YT (YT),
            .ROW_YB (YT + ROW_H - 1),
            .EDGE   (EDGE),
            .EXT    (EXT)
        ) u_contact (
            .live    (row_live[r]),
            .ball_x_l(bxl_q),
            .ball_x_r(bxr_q),
            .ball_y_t(byt_q),
            .ball_y_b(byb_q),
            .contact (contact_d[r])
        );
    end

    // Lowest-index contacting live brick wins; its sides are reported together.
    always_comb begin
        row_live    = '0;
        row_contact = '0;
        svc_sel     = '0;
        svc_sides   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            row_live[r]    = hp_q[r] != '0;
            row_contact[r] = row_live[r] && (contact_q[r] != '0);
        end
        any_contact = |row_contact;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_contact[r]) begin
                svc_sel    = '0;
                svc_sel[r] = 1'b1;
                svc_sides  = contact_q[r];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_contact) begin
                    state_d = StLock;
                    fire    = 1'b1;
                end
            end
            StLock: begin
                if (!any_contact) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (restart) begin
            state_d = StIdle;
            fire    = 1'b0;
        end
    end

    always_comb begin
        hp_d        = hp_q;
        move_d      = '0;
        hit_count_d = hit_count_q;
        score_d     = score_q;
        killed      = 1'b0;
        if (fire) begin
            move_d = svc_sides;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (svc_sel[r]) begin
                    hp_d[r] = hp_q[r] - HP_W'(1);
                    killed  = hp_q[r] == HP_W'(1);
                end
            end
            if (killed) begin
                hit_count_d = hit_count_q + 5'd1;
                if (int'(score_q) + POINTS > SCORE_MAX) begin
                    score_d = '1;
                end else begin
                    score_d = score_q + SCORE_W'(POINTS);
                end
            end
        end
        if (restart) begin
            hp_d        = {NUM_ROWS{HP_FULL}};
            hit_count_d = '0;
            score_d     = '0;
        end
        cleared_d = (hp_q == '0) && !restart;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bxl_q       <= '0;
            bxr_q       <= '0;
            byt_q       <= '0;
            byb_q       <= '0;
            contact_q   <= '0;
            hp_q        <= {NUM_ROWS{HP_FULL}};
            state_q     <= StIdle;
            move_q      <= '0;
            hit_count_q <= '0;
            score_q     <= '0;
            cleared_q   <= 1'b0;
        end else begin
            bxl_q       <= restart ? '0 : ball_x_l;
            bxr_q       <= restart ? '0 : ball_x_r;
            byt_q       <= restart ? '0 : ball_y_t;
            byb_q       <= restart ? '0 : ball_y_b;
            contact_q   <= restart ? '0 : contact_d;
            hp_q        <= hp_d;
            state_q     <= state_d;
            move_q      <= move_d;
            hit_count_q <= hit_count_d;
            score_q     <= score_d;
            cleared_q   <= cleared_d;
        end
    end

    // Render straight from the live HP so a destroyed brick blanks right away.
    always_comb begin
        int px, py, yt;
        col_on    = 1'b0;
        col_shade = '0;
        px        = {{(32 - COORD_W){1'b0}}, pix_x};
        py        = {{(32 - COORD_W){1'b0}}, pix_y};
        for (int r = 0; r < NUM_ROWS; r++) begin
            yt = row_top(Y_TOP, ROW_H, ROW_GAP, r);
            if (px >= X_LEFT && px <= X_RIGHT && py >= yt && py <= yt + ROW_H - 1
                && hp_q[r] != '0) begin
                col_on    = 1'b1;
                col_shade = hp_q[r];
            end
        end
    end

    assign moveU     = move_q.u;
    assign moveD     = move_q.d;
    assign moveL     = move_q.l;
    assign moveR     = move_q.r;
    assign hit_count = hit_count_q;
    assign score     = score_q;
    assign cleared   = cleared_q;

endmodule

// File: doc/breakout_block_column.md
# breakout_block_column

Parametrised brick column for the breakout playfield: one vertical stack of `NUM_ROWS` bricks at a fixed x span.
- Draws the live bricks on the pixel stream.
- Detects ball contact with any brick side and emits one-cycle bounce pulses to the ball controller.
- Supports multi-hit bricks (`HIT_POINTS`), with a brightness level that drops as a brick takes damage.
- Counts destroyed bricks and accumulates a weighted score for the score display.
- One instance per column in the top level.

## Interface
Parameters:
- `NUM_ROWS`, 8, bricks in the column (1..16).
- `X_LEFT`, 461, left pixel edge of every brick.
- `X_RIGHT`, 566, right pixel edge (inclusive).
- `Y_TOP`, 4, top edge of row 0.
- `ROW_H`, 16, brick height in pixels.
- `ROW_GAP`, 7, vertical gap between rows.
- `EDGE`, 3, depth of the side-contact band.
- `EXT`, 7, horizontal overhang allowed for top/bottom contact.
- `HIT_POINTS`, 1, hits needed to destroy a brick (1..3).
- `POINTS`, 4, score added per destroyed brick.
- `SCORE_W`, 8, score width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `restart` in 1: synchronous refill of the column; level-sensitive.
- `pix_x`, `pix_y` in 11: current pixel.
- `ball_x_l`, `ball_x_r`, `ball_y_t`, `ball_y_b` in 11: ball bounding box.
- `moveU`, `moveD`, `moveL`, `moveR` out 1: bounce pulses.
- `col_on` out 1: current pixel lies on a live brick.
- `col_shade` out 2: remaining HP of the brick under the pixel; 0 when `col_on`=0.
- `hit_count` out 5: bricks destroyed.
- `score` out `SCORE_W`: accumulated score.
- `cleared` out 1: all bricks destroyed.

## Operation
Row geometry:
- Row r spans `yt(r)=Y_TOP+r*(ROW_H+ROW_GAP)` to `yb(r)=yt(r)+ROW_H-1`.
- Each brick holds an HP register of 2 bits; the brick is live while HP≠0.

Contact terms for live brick r:
- R: `X_RIGHT-EDGE ≤ ball_x_l ≤ X_RIGHT` and `ball_y_b ≥ yt` and `ball_y_t ≤ yb`.
- L: `X_LEFT ≤ ball_x_r ≤ X_LEFT+EDGE`, same y overlap as R.
- D: `ball_x_l ≥ X_LEFT-EXT` and `ball_x_r ≤ X_RIGHT+EXT` and `yb-EDGE ≤ ball_y_t ≤ yb`.
- U: same x window as D, and `yt ≤ ball_y_b ≤ yt+EDGE`.

Arbitration:
- Only the lowest-index contacting brick is serviced in a cycle.
- All of that brick's matching sides are reported together. Corner hits therefore pulse two directions.

Lockout FSM, with states IDLE and LOCK:
- IDLE → LOCK on a serviced hit.
- LOCK → IDLE after one cycle in which no live brick has any contact term.
- No hit is serviced in LOCK, so one ball pass costs exactly one HP.

On a serviced hit:
- HP decrements.
- If HP reaches 0: `hit_count` +1, and `score` += `POINTS`. Score saturates at 2^`SCORE_W`-1 and never wraps.

Other rules:
- `cleared` = all HP zero, registered.
- `reset` (async) or `restart` (sync): every HP←`HIT_POINTS`, FSM←IDLE, all outputs 0. `restart` wins over a simultaneous hit.
- Reset values: `moveU/D/L/R`=0, `hit_count`=0, `score`=0, `cleared`=0.

## Timing
- Render path is combinational from `pix_*` and the current HP. A brick hit at edge E is blank from E+1 onward.
- Contact stage: ball inputs sampled at edge N; per-brick/side contact flags are registered at N+1.
- Service stage: at edge N+2, the HP update, `move*` pulse (exactly 1 cycle), `hit_count`, `score` and FSM transition all take effect together.
- `cleared` rises at N+3.
- A contact during LOCK produces no pulse and no HP change.
- A ball that remains in contact does not re-fire until one clean cycle has passed.
- `reset` asserted mid-pipeline clears the contact stage; no pulse emerges after release.

## Structure
- Package `breakout_pkg`:
  - pixel coordinate width (11);
  - default playfield constants;
  - the `row_top(r)` function;
  - the HP width.
- Sub-module `brick_contact`: combinational four-side contact test for a single brick, instantiated `NUM_ROWS` times.
- Arbitration, HP array, FSM and scoring stay in the top module.

## Test plan
- Ball box (x_l=563, y_t=30, y_b=37), defaults: `moveR` pulses one cycle at N+2, row 1 blanks, `hit_count`=1, `score`=4.
- Ball box (x_l=470, x_r=477, y_t=62) held for 10 cycles: exactly one `moveD` pulse. After the ball moves away and back, a second hit lands on row 2 only if it is still live.
- `HIT_POINTS`=3, hit row 0 three times with clean gaps: `col_shade` goes 3→2→1, then `col_on` goes 0 and `score` goes 4.
- Ball overlapping the bottom of row 3 and the top of row 4 simultaneously: row 3 is serviced, `moveD`=1, and row 4 is untouched.
- `SCORE_W`=4, `POINTS`=4, destroy 8 bricks: `score` saturates at 15, `hit_count`=8, `cleared`=1 at N+3 after the last hit.
- `reset` asserted one cycle after contact: no `move*` pulse, all bricks restored, outputs 0. The same sequence with `restart` gives an identical result.
